pd_header_assembler: RTL and testbench
======================================

Name: pd_header_assembler

Overview:
- Upstream feeder of the packet decoder's chunk decoder.
- Collects an 80-byte (640-bit) block header arriving as 32-bit words over a valid/ready handshake.
- Packs the header into the 512-bit chunk_1 (words 0..15) and the 128-bit chunk_2 (words 16..19).
- Sequences hash_select through the first 512-bit block, then the padded second block, with a valid/ready handshake to the hasher.

Parameters:
- WORD_WIDTH, 32, input word width. Fixed; the chunk packing rules below are defined for 32.
- HEADER_WORDS, 20, words per header (16 for chunk_1 + 4 for chunk_2).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- word_in  input  32  header word; big-endian word order, word 0 first.
- word_valid  input  1  word_in is valid this cycle.
- word_ready  output  1  block accepts a word this cycle.
- clear  input  1  synchronous abort/resync of a partially collected header.
- hash_ready  input  1  hasher accepts the currently selected 512-bit block.
- hash_valid  output  1  selected block is ready for the hasher.
- hash_select  output  2  0 = chunk_1 block, 1 = chunk_2 padded block; values 2 and 3 are never driven.
- chunk_1  output  512  header words 0..15.
- chunk_2  output  128  header words 16..19.
- word_count  output  5  words accepted in the current header, 0..19.
- header_done  output  1  one-cycle pulse: both blocks consumed by the hasher.

Behaviour:
- Reset (n_rst low, asynchronous):
  - state = COLLECT.
  - chunk_1, chunk_2, word_count, hash_select, hash_valid and header_done all 0.
  - word_ready = 1 while in COLLECT, including during and immediately after reset.
- Output decode:
  - word_ready = (state == COLLECT).
  - hash_valid = (state == HASH1 or HASH2).
  - hash_select = 1 only in HASH2, otherwise 0.
  - chunk_1, chunk_2, word_count and header_done are registered.
- Accept: a word is accepted when word_valid && word_ready at a rising clk edge. Writes outside COLLECT are ignored and storage is unchanged.
- Packing for accepted word index i:
  - i in 0..15: written to chunk_1[511-32i -: 32].
  - i in 16..19: written to chunk_2[127-32(i-16) -: 32].
  - Unwritten slots keep their prior value.
- COLLECT:
  - Each accept increments word_count.
  - On accepting index 19: word_count wraps to 0 and state goes to HASH1 the next cycle.
  - Zero gaps between words are allowed; gaps of any length are also allowed.
- HASH1:
  - Hold until hash_ready = 1 at a clk edge, then go to HASH2.
  - chunk_1 and chunk_2 are stable throughout.
- HASH2:
  - Hold until hash_ready = 1, then go to COLLECT.
  - header_done = 1 for exactly the next cycle.
  - word_ready returns in that same cycle.
- hash_ready while in COLLECT is ignored.
- clear (synchronous, highest priority below reset):
  - Effect at the next edge: state = COLLECT, word_count = 0, hash_valid = 0, header_done = 0.
  - chunk_1 and chunk_2 are cleared to 0.
  - A word presented in the same cycle as clear is dropped.
  - clear during HASH1 or HASH2 aborts the hash sequence; no header_done is produced.
- No overflow is possible: word_ready is low while hashing, so upstream must stall.
- Reset mid-operation: immediate return to the reset values above, in any state.

Test Plan:
- Reset check: hold n_rst low for 3 cycles, then release -> all outputs 0 except word_ready = 1; word_count = 0.
- Back-to-back stream: words 0x00000001..0x00000014 on consecutive cycles -> in the cycle after the 20th accept:
  - word_ready = 0, hash_valid = 1, hash_select = 0.
  - chunk_1[511:480] = 0x1, chunk_1[31:0] = 0x10.
  - chunk_2 = 0x00000011_00000012_00000013_00000014.
- Hasher stall: hold hash_ready = 0 for 5 cycles -> hash_select stays 0. Then:
  - Pulse hash_ready -> hash_select = 1.
  - Pulse again -> header_done high exactly 1 cycle, word_ready = 1, word_count = 0.
- Ignored writes and gaps:
  - Assert word_valid every other cycle -> identical chunks to the back-to-back case.
  - Drive word_in = 0xDEADBEEF with word_valid during HASH1 -> chunks unchanged.
- Clear mid-header: clear after 7 words -> word_count = 0, chunks = 0; the next 20 words assemble correctly starting at word 0.
- Abort during hash: assert clear in HASH2 -> no header_done, hash_valid = 0. Separately, assert n_rst in HASH2 -> outputs 0 without waiting for a clk edge.

Source files
------------

// File: rtl/pd_header_assembler.sv
`default_nettype none
// ============================================================================
// Module   : pd_header_assembler
// Purpose  : Packs an 80-byte header from 32-bit words into chunk_1/chunk_2 and
//            sequences both 512-bit blocks to the hasher.
// Revision : 1.0
// ============================================================================
module pd_header_assembler #(
    parameter int WORD_WIDTH   = 32,
    parameter int HEADER_WORDS = 20
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic                  clear,
    input  logic                  hash_ready,
    output logic                  hash_valid,
    output logic [1:0]            hash_select,
    output logic [511:0]          chunk_1,
    output logic [127:0]          chunk_2,
    output logic [4:0]            word_count,
    output logic                  header_done
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HASH1   = 2'd1,
        HASH2   = 2'd2
    } state_t;

    localparam logic [4:0] C_LAST_IDX   = 5'(HEADER_WORDS - 1);
    localparam int         C_C1_WORDS   = 16;
    localparam int         C_C2_WORDS   = HEADER_WORDS - C_C1_WORDS;

    state_t r_state;
    state_t w_next_state;
    logic   w_accept;
    logic   w_hash_done;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_hash_done  = 1'b0;
        case (r_state)
            COLLECT: begin
                w_accept = word_valid;
                if (word_valid && (word_count == C_LAST_IDX)) begin
                    w_next_state = HASH1;
                end
            end
            HASH1: begin
                if (hash_ready) begin
                    w_next_state = HASH2;
                end
            end
            HASH2: begin
                if (hash_ready) begin
                    w_next_state = COLLECT;
                    w_hash_done  = 1'b1;
                end
            end
            default: w_next_state = COLLECT;
        endcase
        // clear overrides everything: drops the concurrent word and any pending completion
        if (clear) begin
            w_next_state = COLLECT;
            w_accept     = 1'b0;
            w_hash_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign word_ready  = (r_state == COLLECT);
    assign hash_valid  = (r_state == HASH1) || (r_state == HASH2);
    assign hash_select = {1'b0, (r_state == HASH2)};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            chunk_1     <= '0;
            chunk_2     <= '0;
            word_count  <= '0;
            header_done <= 1'b0;
        end else if (clear) begin
            chunk_1     <= '0;
            chunk_2     <= '0;
            word_count  <= '0;
            header_done <= 1'b0;
        end else begin
            header_done <= w_hash_done;
            if (w_accept) begin
                word_count <= (word_count == C_LAST_IDX) ? 5'd0 : word_count + 5'd1;
                // word 0 lands in the most significant slot (big-endian order)
                for (int i = 0; i < C_C1_WORDS; i++) begin
                    if (word_count == 5'(i)) begin
                        chunk_1[511 - WORD_WIDTH*i -: WORD_WIDTH] <= word_in;
                    end
                end
                for (int i = 0; i < C_C2_WORDS; i++) begin
                    if (word_count == 5'(C_C1_WORDS + i)) begin
                        chunk_2[127 - WORD_WIDTH*i -: WORD_WIDTH] <= word_in;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pd_header_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pd_header_assembler
// Purpose  : Directed self-checking bench for pd_header_assembler.
// Revision : 1.0
// ============================================================================
module tb_pd_header_assembler;

    logic         clk;
    logic         n_rst;
    logic [31:0]  word_in;
    logic         word_valid;
    logic         word_ready;
    logic         clear;
    logic         hash_ready;
    logic         hash_valid;
    logic [1:0]   hash_select;
    logic [511:0] chunk_1;
    logic [127:0] chunk_2;
    logic [4:0]   word_count;
    logic         header_done;

    int checks;
    int errors;

    logic [511:0] exp_c1;
    logic [127:0] exp_c2;

    pd_header_assembler #(
        .WORD_WIDTH   (32),
        .HEADER_WORDS (20)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .clear       (clear),
        .hash_ready  (hash_ready),
        .hash_valid  (hash_valid),
        .hash_select (hash_select),
        .chunk_1     (chunk_1),
        .chunk_2     (chunk_2),
        .word_count  (word_count),
        .header_done (header_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected packing of 20 consecutive values starting at base.
    task automatic build_expected(input logic [31:0] base);
        exp_c1 = '0;
        exp_c2 = '0;
        for (int k = 0; k < 16; k++) exp_c1 = {exp_c1[479:0], base + 32'(k)};
        for (int k = 16; k < 20; k++) exp_c2 = {exp_c2[95:0], base + 32'(k)};
    endtask

    // Inputs change on the falling edge; accepts happen on the next rising edge.
    task automatic send_words(input logic [31:0] base, input int count, input bit gaps);
        for (int k = 0; k < count; k++) begin
            @(negedge clk);
            word_in    = base + 32'(k);
            word_valid = 1'b1;
            if (gaps) begin
                @(negedge clk);
                word_valid = 1'b0;
                word_in    = 32'hFFFF_FFFF;
            end
        end
        if (!gaps) begin
            @(negedge clk);
            word_valid = 1'b0;
        end
    endtask

    // Drives both hash handshakes, bounded so a stuck DUT cannot hang the run.
    task automatic drain_hash();
        int budget;
        budget = 0;
        hash_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        hash_ready = 1'b0;
        while (!word_ready && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (!word_ready) begin
            errors++;
            $display("FAIL drain_timeout: word_ready=%0b required 1", word_ready);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (word_ready !== 1'b1) begin
            errors++; $display("FAIL reset_during_ready: got %0b exp 1", word_ready);
        end
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b1 || hash_valid !== 1'b0 || hash_select !== 2'd0 ||
            header_done !== 1'b0 || word_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%0b hv=%0b hs=%0d done=%0b cnt=%0d exp 1 0 0 0 0",
                     word_ready, hash_valid, hash_select, header_done, word_count);
        end
        checks++;
        if (chunk_1 !== '0 || chunk_2 !== '0) begin
            errors++; $display("FAIL reset_chunks: c1=%h c2=%h exp 0", chunk_1, chunk_2);
        end
    endtask

    task automatic test_back_to_back();
        build_expected(32'h1);
        send_words(32'h1, 5, 1'b0);
        checks++;
        if (word_count !== 5'd5) begin
            errors++; $display("FAIL b2b_count5: got %0d exp 5", word_count);
        end
        send_words(32'h6, 15, 1'b0);
        checks++;
        if (word_ready !== 1'b0 || hash_valid !== 1'b1 || hash_select !== 2'd0) begin
            errors++;
            $display("FAIL b2b_hash1: ready=%0b hv=%0b hs=%0d exp 0 1 0",
                     word_ready, hash_valid, hash_select);
        end
        checks++;
        if (chunk_1[511:480] !== 32'h1 || chunk_1[31:0] !== 32'h10) begin
            errors++;
            $display("FAIL b2b_c1_ends: top=%h bot=%h exp 00000001 00000010",
                     chunk_1[511:480], chunk_1[31:0]);
        end
        checks++;
        if (chunk_2 !== 128'h00000011_00000012_00000013_00000014) begin
            errors++; $display("FAIL b2b_c2: got %h exp 00000011000000120000001300000014", chunk_2);
        end
        checks++;
        if (chunk_1 !== exp_c1 || word_count !== 5'd0) begin
            errors++; $display("FAIL b2b_c1_full: got %h cnt=%0d exp %h cnt=0", chunk_1, word_count, exp_c1);
        end
    endtask

    task automatic test_hash_stall();
        hash_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (hash_select !== 2'd0 || hash_valid !== 1'b1) begin
                errors++; $display("FAIL stall_cycle%0d: hs=%0d hv=%0b exp 0 1", k, hash_select, hash_valid);
            end
        end
        hash_ready = 1'b1;
        @(negedge clk);
        hash_ready = 1'b0;
        checks++;
        if (hash_select !== 2'd1 || hash_valid !== 1'b1 || header_done !== 1'b0) begin
            errors++; $display("FAIL stall_hash2: hs=%0d hv=%0b done=%0b exp 1 1 0", hash_select, hash_valid, header_done);
        end
        @(negedge clk);
        hash_ready = 1'b1;
        @(negedge clk);
        hash_ready = 1'b0;
        checks++;
        if (header_done !== 1'b1 || word_ready !== 1'b1 || word_count !== 5'd0 || hash_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done=%0b ready=%0b cnt=%0d hv=%0b exp 1 1 0 0",
                     header_done, word_ready, word_count, hash_valid);
        end
        @(negedge clk);
        checks++;
        if (header_done !== 1'b0) begin
            errors++; $display("FAIL stall_done_pulse: done=%0b exp 0", header_done);
        end
    endtask

    task automatic test_gaps_and_ignored();
        build_expected(32'h1);
        send_words(32'h1, 20, 1'b1);
        checks++;
        if (chunk_1 !== exp_c1 || chunk_2 !== exp_c2 || hash_valid !== 1'b1) begin
            errors++; $display("FAIL gaps_chunks: c1=%h c2=%h hv=%0b exp %h %h 1", chunk_1, chunk_2, hash_valid, exp_c1, exp_c2);
        end
        word_in    = 32'hDEADBEEF;
        word_valid = 1'b1;
        repeat (3) @(negedge clk);
        word_valid = 1'b0;
        checks++;
        if (chunk_1 !== exp_c1 || chunk_2 !== exp_c2 || word_count !== 5'd0) begin
            errors++; $display("FAIL ignored_write: c1=%h c2=%h cnt=%0d exp %h %h 0", chunk_1, chunk_2, word_count, exp_c1, exp_c2);
        end
        drain_hash();
    endtask

    task automatic test_clear_mid();
        send_words(32'h100, 7, 1'b0);
        checks++;
        if (word_count !== 5'd7 || chunk_1[511:480] !== 32'h100) begin
            errors++; $display("FAIL clear_pre: cnt=%0d top=%h exp 7 00000100", word_count, chunk_1[511:480]);
        end
        @(negedge clk);
        clear      = 1'b1;
        word_valid = 1'b1;
        word_in    = 32'hAAAA_AAAA;
        @(negedge clk);
        clear      = 1'b0;
        word_valid = 1'b0;
        checks++;
        if (word_count !== 5'd0 || chunk_1 !== '0 || chunk_2 !== '0 || word_ready !== 1'b1) begin
            errors++; $display("FAIL clear_state: cnt=%0d c1=%h c2=%h ready=%0b exp 0 0 0 1", word_count, chunk_1, chunk_2, word_ready);
        end
        build_expected(32'h200);
        send_words(32'h200, 20, 1'b0);
        checks++;
        if (chunk_1 !== exp_c1 || chunk_2 !== exp_c2 || hash_valid !== 1'b1) begin
            errors++; $display("FAIL clear_reassemble: c1=%h c2=%h hv=%0b exp %h %h 1", chunk_1, chunk_2, hash_valid, exp_c1, exp_c2);
        end
        drain_hash();
    endtask

    task automatic test_abort();
        send_words(32'h300, 20, 1'b0);
        hash_ready = 1'b1;
        @(negedge clk);
        hash_ready = 1'b1;
        clear      = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        hash_ready = 1'b0;
        checks++;
        if (header_done !== 1'b0 || hash_valid !== 1'b0 || word_ready !== 1'b1 || chunk_1 !== '0) begin
            errors++; $display("FAIL abort_clear: done=%0b hv=%0b ready=%0b c1_top=%h exp 0 0 1 0", header_done, hash_valid, word_ready, chunk_1[511:480]);
        end
        @(negedge clk);
        checks++;
        if (header_done !== 1'b0) begin
            errors++; $display("FAIL abort_clear_nodone: done=%0b exp 0", header_done);
        end
        send_words(32'h400, 20, 1'b0);
        hash_ready = 1'b1;
        @(negedge clk);
        hash_ready = 1'b0;
        checks++;
        if (hash_select !== 2'd1) begin
            errors++; $display("FAIL abort_pre_rst: hs=%0d exp 1", hash_select);
        end
        #1;
        n_rst = 1'b0;
        #1;
        checks++;
        if (hash_valid !== 1'b0 || hash_select !== 2'd0 || word_ready !== 1'b1 ||
            chunk_1 !== '0 || chunk_2 !== '0 || word_count !== 5'd0 || header_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_async_rst: hv=%0b hs=%0d ready=%0b cnt=%0d done=%0b exp 0 0 1 0 0",
                     hash_valid, hash_select, word_ready, word_count, header_done);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        n_rst      = 1'b1;
        word_in    = '0;
        word_valid = 1'b0;
        clear      = 1'b0;
        hash_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_hash_stall();
        test_gaps_and_ignored();
        test_clear_mid();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
